scan_misr_checker: RTL and testbench

- Downstream response-analysis stage of the per-scan BIST path.
- Compacts the scan-chain unload stream into a multiple-input signature register (MISR) and counts shift beats and patterns.
- After the programmed pattern count, compares the signature against a golden value and reports pass_nfail / bist_end to the BIST top level.

---
 rtl/scan_misr_checker.sv | 182 ++++++++++++++++++
 tb/tb_scan_misr_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_misr_checker.sv
// rtl/scan_misr_checker.sv - MISR response compactor and signature checker for scan BIST
//
// Purpose:
//   Compacts the scan-chain unload stream into a multiple-input signature
//   register, counts shift beats and pattern unloads, and after the last
//   beat of the last pattern compares the signature with GOLDEN and reports
//   the verdict to the BIST top level.
//
// Optional feature (macro SCAN_X_MASK_EN):
//   Adds i_so_mask after i_so_data. Masked chains contribute 0 to the MISR
//   so unknown capture bits cannot corrupt the signature. Without the macro
//   the port is absent and so_data is compacted unmasked.
//
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_start       one-cycle pulse; seeds the MISR and begins a run
//   i_shift_en    a valid unload beat is on i_so_data this cycle
//   i_so_data     scan-out bits, one per chain
//   i_so_mask     per-chain X mask (SCAN_X_MASK_EN only)
//   o_busy        high from the start edge until DONE is entered
//   o_bist_end    run complete; held until next start or reset
//   o_pass_nfail  1 = signature matched GOLDEN; valid while o_bist_end=1
//   o_signature   current MISR contents

module scan_misr_checker #(
  parameter int                CHAINS     = 4,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] POLY       = 16'h1021,
  parameter int                CHAIN_LEN  = 16,
  parameter int                N_PATTERNS = 100,
  parameter logic [MISR_W-1:0] GOLDEN     = 16'h0000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_shift_en,
  input  logic [CHAINS-1:0] i_so_data,
`ifdef SCAN_X_MASK_EN
  input  logic [CHAINS-1:0] i_so_mask,
`endif
  output logic              o_busy,
  output logic              o_bist_end,
  output logic              o_pass_nfail,
  output logic [MISR_W-1:0] o_signature
);

  // Counter widths: at least one bit even for a terminal count of 1.
  localparam int BEAT_W = (CHAIN_LEN  > 1) ? $clog2(CHAIN_LEN)  : 1;
  localparam int PAT_W  = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(N_PATTERNS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic [MISR_W-1:0] r_misr;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [PAT_W-1:0]  r_pat_cnt;
  logic              r_busy;
  logic              r_bist_end;
  logic              r_pass_nfail;

  logic [CHAINS-1:0] w_chain_bits;
  logic [MISR_W-1:0] w_misr_in;
  logic [MISR_W-1:0] w_misr_next;
  logic              w_start_acc;
  logic              w_beat;
  logic              w_beat_last;
  logic              w_pat_last;
  logic              w_run_end;

  // Masked chains are forced to 0 before compaction.
`ifdef SCAN_X_MASK_EN
  assign w_chain_bits = i_so_data & ~i_so_mask;
`else
  assign w_chain_bits = i_so_data;
`endif

  // so_data[i] feeds MISR bit i; chains above CHAINS are zero-extended.
  always_comb begin
    w_misr_in                 = '0;
    w_misr_in[CHAINS-1:0]     = w_chain_bits;
  end

  // Galois-style shift: MSB out selects the feedback polynomial.
  always_comb begin
    w_misr_next = {r_misr[MISR_W-2:0], 1'b0}
                ^ (r_misr[MISR_W-1] ? POLY : {MISR_W{1'b0}})
                ^ w_misr_in;
  end

  // start is honoured only when no run is in flight; a start in RUN or
  // COMPARE is dropped without effect.
  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Beats are only compacted in RUN, so a shift_en coincident with an
  // accepted start (state still IDLE/DONE) is neither compacted nor counted.
  assign w_beat      = (r_state == S_RUN) && i_shift_en;
  assign w_beat_last = (r_beat_cnt == BEAT_LAST);
  assign w_pat_last  = (r_pat_cnt == PAT_LAST);
  assign w_run_end   = w_beat && w_beat_last && w_pat_last;

  // Control FSM.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_start_acc) r_state <= S_RUN;
        S_RUN:     if (w_run_end)   r_state <= S_COMPARE;
        S_COMPARE: r_state <= S_DONE;
        S_DONE:    if (w_start_acc) r_state <= S_RUN;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Signature register: reseeded on start, advanced once per RUN beat,
  // otherwise held (stall, COMPARE, DONE).
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_misr <= '0;
    end else if (w_start_acc) begin
      r_misr <= '0;
    end else if (w_beat) begin
      r_misr <= w_misr_next;
    end
  end

  // Beat / pattern counters. The terminal counts are decoded, so the
  // counters never need to represent values beyond CHAIN_LEN-1 and
  // N_PATTERNS-1.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_beat_cnt <= '0;
      r_pat_cnt  <= '0;
    end else if (w_start_acc) begin
      r_beat_cnt <= '0;
      r_pat_cnt  <= '0;
    end else if (w_beat) begin
      if (w_beat_last) begin
        r_beat_cnt <= '0;
        if (w_pat_last) begin
          r_pat_cnt <= '0;
        end else begin
          r_pat_cnt <= r_pat_cnt + 1'b1;
        end
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  // Status flags. The verdict is registered in the single COMPARE cycle, so
  // bist_end rises two edges after the final beat and busy falls with it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_busy       <= 1'b0;
      r_bist_end   <= 1'b0;
      r_pass_nfail <= 1'b0;
    end else if (w_start_acc) begin
      r_busy       <= 1'b1;
      r_bist_end   <= 1'b0;
      r_pass_nfail <= 1'b0;
    end else if (r_state == S_COMPARE) begin
      r_busy       <= 1'b0;
      r_bist_end   <= 1'b1;
      r_pass_nfail <= (r_misr == GOLDEN);
    end
  end

  assign o_busy       = r_busy;
  assign o_bist_end   = r_bist_end;
  assign o_pass_nfail = r_pass_nfail;
  assign o_signature  = r_misr;

endmodule

// File: tb/tb_scan_misr_checker.sv
// tb/tb_scan_misr_checker.sv - directed self-checking bench for scan_misr_checker

module tb_scan_misr_checker;

  logic        i_clock;
  logic        i_reset;
  logic        i_start;
  logic        i_shift_en;
  logic [3:0]  i_so_data;
  logic [3:0]  i_so_mask;

  logic        a_busy, a_bist_end, a_pass_nfail;
  logic [15:0] a_signature;
  logic        b_busy, b_bist_end, b_pass_nfail;
  logic [15:0] b_signature;

  int n_tests = 0;
  int n_fail  = 0;

  // dut_a: short run (4 beats x 2 patterns) for the end-to-end verdict.
  scan_misr_checker #(
    .CHAINS(4), .MISR_W(16), .POLY(16'h1021),
    .CHAIN_LEN(4), .N_PATTERNS(2), .GOLDEN(16'h0000)
  ) dut_a (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_shift_en   (i_shift_en),
    .i_so_data    (i_so_data),
`ifdef SCAN_X_MASK_EN
    .i_so_mask    (i_so_mask),
`endif
    .o_busy       (a_busy),
    .o_bist_end   (a_bist_end),
    .o_pass_nfail (a_pass_nfail),
    .o_signature  (a_signature)
  );

  // dut_b: long run so the MISR can be walked up to 0x8000 and past it.
  scan_misr_checker #(
    .CHAINS(4), .MISR_W(16), .POLY(16'h1021),
    .CHAIN_LEN(4), .N_PATTERNS(8), .GOLDEN(16'h0000)
  ) dut_b (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_shift_en   (i_shift_en),
    .i_so_data    (i_so_data),
`ifdef SCAN_X_MASK_EN
    .i_so_mask    (i_so_mask),
`endif
    .o_busy       (b_busy),
    .o_bist_end   (b_bist_end),
    .o_pass_nfail (b_pass_nfail),
    .o_signature  (b_signature)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic beat(input logic [3:0] d, input logic [3:0] m);
    i_shift_en = 1'b1;
    i_so_data  = d;
    i_so_mask  = m;
    tick();
    i_shift_en = 1'b0;
    i_so_data  = 4'h0;
    i_so_mask  = 4'h0;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    repeat (3) tick();
    i_reset = 1'b1;
    tick();
  endtask

  logic [3:0] pat_data [8];
  logic [15:0] exp_fail_sig;
  logic        exp_fail_pass;

  initial begin
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_shift_en = 1'b0;
    i_so_data  = 4'h0;
    i_so_mask  = 4'h0;
    pat_data   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};

    // 1. Reset state held for 3 cycles, then released.
    repeat (3) tick();
    check("rst_busy",   {31'd0, a_busy},       32'd0);
    check("rst_end",    {31'd0, a_bist_end},   32'd0);
    check("rst_pass",   {31'd0, a_pass_nfail}, 32'd0);
    check("rst_sig",    {16'd0, a_signature},  32'h0000);
    i_reset = 1'b1;
    tick();
    check("rel_busy",   {31'd0, a_busy},       32'd0);

    // 2. Single beat and feedback wrap.
    pulse_start();
    check("st_busy",    {31'd0, b_busy},       32'd1);
    beat(4'b0001, 4'h0);
    check("beat1_sig",  {16'd0, b_signature},  32'h0001);
    repeat (15) beat(4'h0, 4'h0);
    check("preload",    {16'd0, b_signature},  32'h8000);
    beat(4'h0, 4'h0);
    check("poly_fb",    {16'd0, b_signature},  32'h1021);

    // Asynchronous reset mid-run: outputs clear without a clock edge.
    #2;
    i_reset = 1'b0;
    #1;
    check("arst_sig",   {16'd0, b_signature},  32'h0000);
    check("arst_busy",  {31'd0, b_busy},       32'd0);
    check("arst_end",   {31'd0, a_bist_end},   32'd0);
    do_reset();

    // 3. All-zero run: bist_end exactly two edges after the 8th beat.
    pulse_start();
    check("z_sig0",     {16'd0, a_signature},  32'h0000);
    repeat (8) beat(4'h0, 4'h0);
    check("z_end_e1",   {31'd0, a_bist_end},   32'd0);
    check("z_busy_e1",  {31'd0, a_busy},       32'd1);
    tick();
    check("z_end_e2",   {31'd0, a_bist_end},   32'd1);
    check("z_busy_e2",  {31'd0, a_busy},       32'd0);
    check("z_pass",     {31'd0, a_pass_nfail}, 32'd1);
    check("z_sig",      {16'd0, a_signature},  32'h0000);
    tick();
    check("z_hold",     {31'd0, a_bist_end},   32'd1);

    // Failing run (beat 5 = 1000), started from DONE. With the X mask
    // build, the same beat is masked and the run passes.
`ifdef SCAN_X_MASK_EN
    exp_fail_sig  = 16'h0000;
    exp_fail_pass = 1'b1;
`else
    exp_fail_sig  = 16'h0040;
    exp_fail_pass = 1'b0;
`endif
    pulse_start();
    check("rs_end_clr", {31'd0, a_bist_end},   32'd0);
    check("rs_busy",    {31'd0, a_busy},       32'd1);
    for (int i = 0; i < 8; i++) beat(pat_data[i], (i == 4) ? 4'b1000 : 4'b0000);
    tick();
    check("f_end",      {31'd0, a_bist_end},   32'd1);
    check("f_pass",     {31'd0, a_pass_nfail}, {31'd0, exp_fail_pass});
    check("f_sig",      {16'd0, a_signature},  {16'd0, exp_fail_sig});

    // 4. Same pattern with stalls of 1 and 5 cycles, no mask.
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      beat(pat_data[i], 4'h0);
      if (i == 1) repeat (1) tick();
      if (i == 4) repeat (5) tick();
    end
    check("s_end_e1",   {31'd0, a_bist_end},   32'd0);
    tick();
    check("s_end_e2",   {31'd0, a_bist_end},   32'd1);
    check("s_pass",     {31'd0, a_pass_nfail}, 32'd0);
    check("s_sig",      {16'd0, a_signature},  32'h0040);

    // 5. start coincident with shift_en: that beat is dropped.
    i_start    = 1'b1;
    i_shift_en = 1'b1;
    i_so_data  = 4'b0001;
    tick();
    i_start    = 1'b0;
    i_shift_en = 1'b0;
    i_so_data  = 4'h0;
    check("c_sig",      {16'd0, a_signature},  32'h0000);
    repeat (3) beat(4'h0, 4'h0);
    // start during RUN must not restart the beat count.
    pulse_start();
    check("r_busy",     {31'd0, a_busy},       32'd1);
    repeat (4) beat(4'h0, 4'h0);
    tick();
    tick();
    check("c_7beats",   {31'd0, a_bist_end},   32'd0);
    beat(4'h0, 4'h0);
    tick();
    check("c_8beats",   {31'd0, a_bist_end},   32'd1);
    check("c_pass",     {31'd0, a_pass_nfail}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
